cronometro_regressivo_multi: RTL and testbench

//  Parametrised countdown (shot) clock with N selectable presets, internal 1 s prescaler,

---
 rtl/cronometro_regressivo_multi_if.sv | 49 ++++
 rtl/cronometro_regressivo_multi.sv | 171 +++++++++++++++++
 tb/tb_cronometro_regressivo_multi.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cronometro_regressivo_multi_if.sv
// ---------------------------------------------------------------------------
// cronometro_regressivo_multi_if
// Purpose : groups the control inputs and display/buzzer outputs of the
//           countdown shot clock into one bundle. Clock and reset stay as
//           plain ports on the module itself.
// Signals :
//   reload      controller -> clock   level, loads the selected preset
//   sel_preset  controller -> clock   preset index, looked at on reset/reload
//   pause       controller -> clock   1 freezes count and prescaler
//   count       clock -> controller   seconds remaining
//   sec_tick    clock -> controller   one-cycle pulse on each decrement
//   expired     clock -> controller   high while sitting at zero
//   buzzer      clock -> controller   timed pulse starting at expiry
// Modports: master = controller side (testbench), slave = the clock block.
// ---------------------------------------------------------------------------
interface cronometro_regressivo_multi_if #(
  parameter int WIDTH = 5,
  parameter int SELW  = 1
) ();

  logic             reload;
  logic [SELW-1:0]  sel_preset;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             sec_tick;
  logic             expired;
  logic             buzzer;

  modport master (
    output reload,
    output sel_preset,
    output pause,
    input  count,
    input  sec_tick,
    input  expired,
    input  buzzer
  );

  modport slave (
    input  reload,
    input  sel_preset,
    input  pause,
    output count,
    output sec_tick,
    output expired,
    output buzzer
  );

endinterface

// File: rtl/cronometro_regressivo_multi.sv
// ---------------------------------------------------------------------------
// cronometro_regressivo_multi
// Purpose : countdown (shot) clock with NUM_PRESETS selectable starting
//           values, an internal prescaler that turns TICKS_PER_SEC clock
//           cycles into one count step, pause, reload and a buzzer pulse of
//           BUZZ_CYCLES cycles when the count reaches zero. One counter
//           serves every preset; the preset is chosen at reset/reload time.
// Ports   :
//   clock_in  in   single clock, everything updates on its rising edge
//   reset     in   synchronous, active-high
//   bus       slave modport of cronometro_regressivo_multi_if:
//             reload, sel_preset, pause in; count, sec_tick, expired,
//             buzzer out (all outputs come straight from registers)
// ---------------------------------------------------------------------------
module cronometro_regressivo_multi #(
  parameter int                           WIDTH         = 5,
  parameter int                           NUM_PRESETS   = 2,
  parameter logic [WIDTH*NUM_PRESETS-1:0] PRESETS       = {5'd24, 5'd14},
  parameter int                           TICKS_PER_SEC = 50_000_000,
  parameter int                           BUZZ_CYCLES   = 50_000_000
) (
  input logic                         clock_in,
  input logic                         reset,
  cronometro_regressivo_multi_if.slave bus
);

  localparam int SELW = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1;
  localparam int PW   = $clog2(TICKS_PER_SEC + 1);
  localparam int BW   = $clog2(BUZZ_CYCLES + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BUZZ_LAST  = BW'(BUZZ_CYCLES - 1);

  // The registered state only separates "still counting" from "expired".
  // RUN and HOLD are split combinationally from the live pause input so a
  // pause takes effect on the very edge it is sampled.
  typedef enum logic [1:0] {
    ST_RUN,
    ST_HOLD,
    ST_EXP
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  state_t           w_mode;

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_presc;
  logic             r_secTick;
  logic             r_expired;
  logic             r_buzzer;
  logic [BW-1:0]    r_buzzCnt;

  logic [WIDTH-1:0] w_countNext;
  logic [PW-1:0]    w_prescNext;
  logic             w_tickNext;
  logic             w_expNext;
  logic             w_buzzNext;
  logic [BW-1:0]    w_buzzCntNext;

  logic [WIDTH-1:0] w_preset;
  logic             w_presetZero;

  // Preset lookup. Out-of-range indices match no entry and fall back to
  // entry 0, which is the default loaded before the search.
  always_comb begin
    w_preset = PRESETS[WIDTH-1:0];
    for (int i = 0; i < NUM_PRESETS; i++) begin
      if (bus.sel_preset == SELW'(i)) begin
        w_preset = PRESETS[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_presetZero = (w_preset == '0);

  // Effective mode for this cycle: expired wins, otherwise pause picks HOLD.
  assign w_mode = (r_state == ST_EXP) ? ST_EXP :
                  (bus.pause ? ST_HOLD : ST_RUN);

  // Next-state and next-value logic. Reload outranks pause and counting;
  // the buzzer countdown runs regardless of pause and is only cut short
  // by reload (here) or reset (in the register block).
  always_comb begin
    w_stateNext   = r_state;
    w_countNext   = r_count;
    w_prescNext   = r_presc;
    w_tickNext    = 1'b0;
    w_expNext     = r_expired;
    w_buzzNext    = r_buzzer;
    w_buzzCntNext = r_buzzCnt;

    // Buzzer stays high for exactly BUZZ_CYCLES cycles: it is loaded with
    // BUZZ_CYCLES-1 and drops on the cycle after the counter hits zero.
    if (r_buzzer) begin
      if (r_buzzCnt == '0) begin
        w_buzzNext = 1'b0;
      end else begin
        w_buzzCntNext = r_buzzCnt - BW'(1);
      end
    end

    if (bus.reload) begin
      w_countNext   = w_preset;
      w_prescNext   = '0;
      w_expNext     = w_presetZero;
      w_buzzNext    = 1'b0;
      w_buzzCntNext = '0;
      w_stateNext   = w_presetZero ? ST_EXP : ST_RUN;
    end else begin
      unique case (w_mode)
        ST_RUN: begin
          if (r_presc == PRESC_LAST) begin
            w_prescNext = '0;
            w_countNext = r_count - WIDTH'(1);
            w_tickNext  = 1'b1;
            // Stepping from 1 to 0 is the only way into expiry with a buzz.
            if (r_count == WIDTH'(1)) begin
              w_expNext     = 1'b1;
              w_buzzNext    = 1'b1;
              w_buzzCntNext = BUZZ_LAST;
              w_stateNext   = ST_EXP;
            end
          end else begin
            w_prescNext = r_presc + PW'(1);
          end
        end
        ST_HOLD: begin
          // Count and partial second are both kept so resume picks up
          // exactly where the pause interrupted.
          w_prescNext = r_presc;
        end
        ST_EXP: begin
          w_countNext = '0;
          w_prescNext = '0;
        end
        default: begin
          w_stateNext = r_state;
        end
      endcase
    end
  end

  // State register. Reset loads the selected preset just like a reload,
  // and additionally clears the tick pulse.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state   <= w_presetZero ? ST_EXP : ST_RUN;
      r_count   <= w_preset;
      r_presc   <= '0;
      r_secTick <= 1'b0;
      r_expired <= w_presetZero;
      r_buzzer  <= 1'b0;
      r_buzzCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_count   <= w_countNext;
      r_presc   <= w_prescNext;
      r_secTick <= w_tickNext;
      r_expired <= w_expNext;
      r_buzzer  <= w_buzzNext;
      r_buzzCnt <= w_buzzCntNext;
    end
  end

  assign bus.count    = r_count;
  assign bus.sec_tick = r_secTick;
  assign bus.expired  = r_expired;
  assign bus.buzzer   = r_buzzer;

endmodule

// File: tb/tb_cronometro_regressivo_multi.sv
// ---------------------------------------------------------------------------
// tb_cronometro_regressivo_multi
// Purpose : self-checking bench for the countdown clock with a 4-cycle
//           second and a 3-cycle buzzer. dutA uses presets {24,14};
//           dutB uses {24,0} to exercise a zero preset. Every decrement
//           of dutA is matched against a queue of expected count values.
// ---------------------------------------------------------------------------
module tb_cronometro_regressivo_multi;

  localparam int WIDTH = 5;
  localparam int NP    = 2;
  localparam int SELW  = 1;
  localparam int TPS   = 4;
  localparam int BUZZ  = 3;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sbQ[$];
  logic [WIDTH-1:0] sbExp;
  bit               sbOn = 1'b0;

  cronometro_regressivo_multi_if #(.WIDTH(WIDTH), .SELW(SELW)) busA ();
  cronometro_regressivo_multi_if #(.WIDTH(WIDTH), .SELW(SELW)) busB ();

  cronometro_regressivo_multi #(
    .WIDTH(WIDTH), .NUM_PRESETS(NP), .PRESETS({5'd24, 5'd14}),
    .TICKS_PER_SEC(TPS), .BUZZ_CYCLES(BUZZ)
  ) dutA (
    .clock_in(clk), .reset(rstA), .bus(busA)
  );

  cronometro_regressivo_multi #(
    .WIDTH(WIDTH), .NUM_PRESETS(NP), .PRESETS({5'd24, 5'd0}),
    .TICKS_PER_SEC(TPS), .BUZZ_CYCLES(BUZZ)
  ) dutB (
    .clock_in(clk), .reset(rstB), .bus(busB)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Scoreboard consumer: every tick from dutA must match the oldest
  // expected count pushed by the running test.
  always @(negedge clk) begin
    if (sbOn && busA.sec_tick === 1'b1) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected_tick: got tick with count %0d, required no tick", busA.count);
      end else begin
        sbExp = sbQ.pop_front();
        if (busA.count !== sbExp) begin
          errors++;
          $display("[TB] FAIL sb_tick_count: got %0d, required %0d", busA.count, sbExp);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rl, input logic [SELW-1:0] sel, input logic ps);
    busA.reload     = rl;
    busA.sel_preset = sel;
    busA.pause      = ps;
  endtask

  // Confirms every expected tick was consumed, then realigns to posedge+1.
  task automatic test_sb_drained(input string tag);
    @(negedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_sb_leftover: got %0d pending ticks, required 0", tag, sbQ.size());
      sbQ.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstA = 1'b1;
    rstB = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    busB.reload     = 1'b0;
    busB.sel_preset = 1'b1;
    busB.pause      = 1'b1;
    step(1);
    rstA = 1'b0;
    rstB = 1'b0;
    checks++;
    if (busA.count !== 5'd24 || busA.expired !== 1'b0 || busA.buzzer !== 1'b0 || busA.sec_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got cnt=%0d exp=%b buz=%b tick=%b, required 24 0 0 0",
               busA.count, busA.expired, busA.buzzer, busA.sec_tick);
    end
    sbOn = 1'b1;
    sbQ.push_back(5'd23);
    busA.pause = 1'b0;
    step(3);
    checks++;
    if (busA.count !== 5'd24 || busA.sec_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_pre_step: got cnt=%0d tick=%b, required 24 0", busA.count, busA.sec_tick);
    end
    step(1);
    checks++;
    if (busA.count !== 5'd23 || busA.sec_tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_first_step: got cnt=%0d tick=%b, required 23 1", busA.count, busA.sec_tick);
    end
    step(1);
    checks++;
    if (busA.count !== 5'd23 || busA.sec_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_tick_width: got cnt=%0d tick=%b, required 23 0", busA.count, busA.sec_tick);
    end
    test_sb_drained("reset");
  endtask

  task automatic test_countdown();
    logic [WIDTH-1:0] expC;
    logic             expT;
    logic             expE;
    logic             expB;
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(1);
    busA.reload = 1'b0;
    checks++;
    if (busA.count !== 5'd14 || busA.expired !== 1'b0) begin
      errors++;
      $display("[TB] FAIL countdown_load: got cnt=%0d exp=%b, required 14 0", busA.count, busA.expired);
    end
    for (int v = 13; v >= 0; v--) sbQ.push_back(WIDTH'(v));
    for (int k = 1; k <= 64; k++) begin
      step(1);
      expC = (k >= 56) ? '0 : WIDTH'(14 - k / 4);
      expT = ((k % 4) == 0) && (k <= 56);
      expE = (k >= 56);
      expB = (k >= 56) && (k <= 58);
      checks++;
      if (busA.count !== expC || busA.sec_tick !== expT || busA.expired !== expE || busA.buzzer !== expB) begin
        errors++;
        $display("[TB] FAIL countdown_cycle_%0d: got cnt=%0d tick=%b exp=%b buz=%b, required %0d %b %b %b",
                 k, busA.count, busA.sec_tick, busA.expired, busA.buzzer, expC, expT, expE, expB);
      end
    end
    test_sb_drained("countdown");
  endtask

  task automatic test_pause();
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(1);
    busA.reload = 1'b0;
    step(2);
    busA.pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      checks++;
      if (busA.count !== 5'd14 || busA.sec_tick !== 1'b0) begin
        errors++;
        $display("[TB] FAIL pause_frozen_%0d: got cnt=%0d tick=%b, required 14 0", k, busA.count, busA.sec_tick);
      end
    end
    busA.pause = 1'b0;
    sbQ.push_back(5'd13);
    step(1);
    checks++;
    if (busA.count !== 5'd14 || busA.sec_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause_resume_1: got cnt=%0d tick=%b, required 14 0", busA.count, busA.sec_tick);
    end
    step(1);
    checks++;
    if (busA.count !== 5'd13 || busA.sec_tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pause_resume_2: got cnt=%0d tick=%b, required 13 1", busA.count, busA.sec_tick);
    end
    test_sb_drained("pause");
  endtask

  task automatic test_reload_during_buzzer();
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(1);
    busA.reload = 1'b0;
    for (int v = 13; v >= 0; v--) sbQ.push_back(WIDTH'(v));
    step(56);
    checks++;
    if (busA.count !== 5'd0 || busA.buzzer !== 1'b1 || busA.expired !== 1'b1) begin
      errors++;
      $display("[TB] FAIL buzz_start: got cnt=%0d buz=%b exp=%b, required 0 1 1", busA.count, busA.buzzer, busA.expired);
    end
    step(1);
    checks++;
    if (busA.buzzer !== 1'b1) begin
      errors++;
      $display("[TB] FAIL buzz_cycle2: got buz=%b, required 1", busA.buzzer);
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    step(1);
    busA.reload = 1'b0;
    checks++;
    if (busA.count !== 5'd24 || busA.buzzer !== 1'b0 || busA.expired !== 1'b0 || busA.sec_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL buzz_reload: got cnt=%0d buz=%b exp=%b tick=%b, required 24 0 0 0",
               busA.count, busA.buzzer, busA.expired, busA.sec_tick);
    end
    step(2);
    checks++;
    if (busA.count !== 5'd24 || busA.buzzer !== 1'b0) begin
      errors++;
      $display("[TB] FAIL buzz_after_reload: got cnt=%0d buz=%b, required 24 0", busA.count, busA.buzzer);
    end
    test_sb_drained("buzz");
  endtask

  task automatic test_reload_vs_tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    step(1);
    busA.reload = 1'b0;
    step(3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(1);
    checks++;
    if (busA.count !== 5'd14 || busA.sec_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reload_wins: got cnt=%0d tick=%b, required 14 0", busA.count, busA.sec_tick);
    end
    for (int k = 0; k < 5; k++) begin
      step(1);
      checks++;
      if (busA.count !== 5'd14 || busA.sec_tick !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reload_held_%0d: got cnt=%0d tick=%b, required 14 0", k, busA.count, busA.sec_tick);
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    sbQ.push_back(5'd13);
    step(3);
    checks++;
    if (busA.count !== 5'd14 || busA.sec_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sel_change_pre: got cnt=%0d tick=%b, required 14 0", busA.count, busA.sec_tick);
    end
    step(1);
    checks++;
    if (busA.count !== 5'd13 || busA.sec_tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sel_change_step: got cnt=%0d tick=%b, required 13 1", busA.count, busA.sec_tick);
    end
    busA.pause = 1'b1;
    test_sb_drained("reload_tick");
  endtask

  task automatic test_zero_preset();
    busB.sel_preset = 1'b0;
    busB.reload     = 1'b1;
    busB.pause      = 1'b0;
    step(1);
    busB.reload = 1'b0;
    checks++;
    if (busB.count !== 5'd0 || busB.expired !== 1'b1 || busB.buzzer !== 1'b0 || busB.sec_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_load: got cnt=%0d exp=%b buz=%b tick=%b, required 0 1 0 0",
               busB.count, busB.expired, busB.buzzer, busB.sec_tick);
    end
    for (int k = 0; k < 10; k++) begin
      step(1);
      checks++;
      if (busB.count !== 5'd0 || busB.expired !== 1'b1 || busB.buzzer !== 1'b0 || busB.sec_tick !== 1'b0) begin
        errors++;
        $display("[TB] FAIL zero_hold_%0d: got cnt=%0d exp=%b buz=%b tick=%b, required 0 1 0 0",
                 k, busB.count, busB.expired, busB.buzzer, busB.sec_tick);
      end
    end
    busB.sel_preset = 1'b1;
    busB.reload     = 1'b1;
    step(1);
    busB.reload = 1'b0;
    checks++;
    if (busB.count !== 5'd24 || busB.expired !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_exit: got cnt=%0d exp=%b, required 24 0", busB.count, busB.expired);
    end
    step(8);
    checks++;
    if (busB.count !== 5'd22) begin
      errors++;
      $display("[TB] FAIL midrun_count: got %0d, required 22", busB.count);
    end
    rstB = 1'b1;
    step(1);
    checks++;
    if (busB.count !== 5'd24 || busB.sec_tick !== 1'b0 || busB.expired !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got cnt=%0d tick=%b exp=%b, required 24 0 0",
               busB.count, busB.sec_tick, busB.expired);
    end
    busB.sel_preset = 1'b0;
    step(1);
    rstB = 1'b0;
    checks++;
    if (busB.count !== 5'd0 || busB.expired !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_zero_preset: got cnt=%0d exp=%b, required 0 1", busB.count, busB.expired);
    end
    step(3);
    checks++;
    if (busB.count !== 5'd0 || busB.buzzer !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_zero_quiet: got cnt=%0d buz=%b, required 0 0", busB.count, busB.buzzer);
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_reload_during_buzzer();
    test_reload_vs_tick();
    test_zero_preset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
